// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared opcodes, ALU-op encodings, instruction field positions
//               and the packed control bundle passed from decode to execute.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int RS_MSB     = 12;
    localparam int RS_LSB     = 10;
    localparam int RT_MSB     = 9;
    localparam int RT_LSB     = 7;
    localparam int IMM_MSB    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'b000,
        OP_LW    = 3'b001,
        OP_SW    = 3'b010,
        OP_BEQ   = 3'b011,
        OP_ADDI  = 3'b100
    } opcode_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Undefined opcodes fall through to an all-zero NOP bundle.
    function automatic ctrl_t decode_ctrl(input logic [2:0] opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_RTYPE;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALU_OP_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_OP_SUB;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_OP_ADD;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipe_if
// Description : Fetch, write-back and ID/EX signal bundle for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_pipe_if #(
    parameter int DATA_W = 16
) ();

    logic              if_valid;
    logic [15:0]       if_instr;
    logic              id_ready;

    logic              wb_we;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              ex_flush;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_rd_data1;
    logic [DATA_W-1:0] ex_rd_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [2:0]        ex_rs;
    logic [2:0]        ex_rt;
    logic              ex_reg_dst;
    logic              ex_alu_src;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic [1:0]        ex_alu_op;

    modport master (
        output if_valid, if_instr, wb_we, wb_addr, wb_data, ex_flush,
        input  id_ready, ex_valid, ex_rd_data1, ex_rd_data2, ex_imm,
               ex_rs, ex_rt, ex_reg_dst, ex_alu_src, ex_mem_to_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op
    );

    modport slave (
        input  if_valid, if_instr, wb_we, wb_addr, wb_data, ex_flush,
        output id_ready, ex_valid, ex_rd_data1, ex_rd_data2, ex_imm,
               ex_rs, ex_rt, ex_reg_dst, ex_alu_src, ex_mem_to_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_op
    );

endinterface
`default_nettype wire

// File: rtl/decode_stage_pipe_regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass
// Description : 8-entry register file, 2 read / 1 write, r0 hard-wired to zero,
//               optional same-cycle write-back forwarding to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [REG_ADDR_W-1:0] rd_addr1,
    input  wire logic [REG_ADDR_W-1:0] rd_addr2,
    output logic      [DATA_W-1:0]     rd_data1,
    output logic      [DATA_W-1:0]     rd_data2,
    input  wire logic                  wr_en,
    input  wire logic [REG_ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_file1;
    logic [DATA_W-1:0] w_file2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign w_file1 = (rd_addr1 == '0) ? '0 : r_regs[rd_addr1];
    assign w_file2 = (rd_addr2 == '0) ? '0 : r_regs[rd_addr2];

    generate
        if (WB_BYPASS) begin : g_bypass
            logic w_hit1;
            logic w_hit2;
            // r0 is excluded so a write to r0 can never leak through.
            assign w_hit1   = wr_en && (wr_addr != '0) && (wr_addr == rd_addr1);
            assign w_hit2   = wr_en && (wr_addr != '0) && (wr_addr == rd_addr2);
            assign rd_data1 = w_hit1 ? wr_data : w_file1;
            assign rd_data2 = w_hit2 ? wr_data : w_file2;
        end else begin : g_no_bypass
            assign rd_data1 = w_file1;
            assign rd_data2 = w_file2;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipe
// Description : Decode stage with register file, immediate sign-extension,
//               control decode, load-use stall, branch flush and ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    decode_stage_pipe_if.slave bus
);

    logic [2:0]        w_opcode;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    ctrl_t             w_ctrl;
    logic              w_hazard;
    logic              w_load;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [DATA_W-1:0] r_imm;
    logic [2:0]        r_rs;
    logic [2:0]        r_rt;

    assign w_opcode  = bus.if_instr[OPCODE_MSB:OPCODE_LSB];
    assign w_rs      = bus.if_instr[RS_MSB:RS_LSB];
    assign w_rt      = bus.if_instr[RT_MSB:RT_LSB];
    assign w_imm     = bus.if_instr[IMM_MSB:IMM_LSB];
    assign w_imm_ext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_ctrl    = decode_ctrl(w_opcode);

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (w_rs),
        .rd_addr2 (w_rt),
        .rd_data1 (w_rd_data1),
        .rd_data2 (w_rd_data2),
        .wr_en    (bus.wb_we),
        .wr_addr  (bus.wb_addr),
        .wr_data  (bus.wb_data)
    );

    // Both source fields are compared regardless of opcode; a spurious stall
    // costs one cycle, a missed one corrupts data.
    assign w_hazard = r_valid && r_ctrl.mem_read && (r_rt != '0) &&
                      ((r_rt == w_rs) || (r_rt == w_rt));

    // Flush wins over a stall so the wrong-path instruction is discarded.
    assign bus.id_ready = bus.ex_flush || !w_hazard;
    assign w_load       = bus.if_valid && !bus.ex_flush && !w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_ctrl     <= w_ctrl;
            r_rd_data1 <= w_rd_data1;
            r_rd_data2 <= w_rd_data2;
            r_imm      <= w_imm_ext;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
        end else begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_NOP;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_rd_data1   = r_rd_data1;
    assign bus.ex_rd_data2   = r_rd_data2;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_rs         = r_rs;
    assign bus.ex_rt         = r_rt;
    assign bus.ex_reg_dst    = r_ctrl.reg_dst;
    assign bus.ex_alu_src    = r_ctrl.alu_src;
    assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.ex_reg_write  = r_ctrl.reg_write;
    assign bus.ex_mem_read   = r_ctrl.mem_read;
    assign bus.ex_mem_write  = r_ctrl.mem_write;
    assign bus.ex_branch     = r_ctrl.branch;
    assign bus.ex_alu_op     = r_ctrl.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_pipe
// Description : Directed self-checking bench; dut_a is 32-bit with bypass,
//               dut_b is 16-bit without bypass, both fed the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipe;
    import decode_pkg::*;

    localparam logic [8:0] C_CTRL_R    = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_CTRL_LW   = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_CTRL_SW   = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_CTRL_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] C_CTRL_ADDI = 9'b0_1_0_1_0_0_0_00;
    localparam logic [8:0] C_CTRL_NONE = 9'b0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(32)) ifa ();
    decode_stage_pipe_if #(.DATA_W(16)) ifb ();

    decode_stage_pipe #(.DATA_W(32), .WB_BYPASS(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    decode_stage_pipe #(.DATA_W(16), .WB_BYPASS(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ctrl_a();
        return {ifa.ex_reg_dst, ifa.ex_alu_src, ifa.ex_mem_to_reg, ifa.ex_reg_write,
                ifa.ex_mem_read, ifa.ex_mem_write, ifa.ex_branch, ifa.ex_alu_op};
    endfunction

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic we,
                         input logic [2:0] wa, input logic [31:0] wd, input logic fl);
        ifa.if_valid = v;   ifb.if_valid = v;
        ifa.if_instr = ins; ifb.if_instr = ins;
        ifa.wb_we    = we;  ifb.wb_we    = we;
        ifa.wb_addr  = wa;  ifb.wb_addr  = wa;
        ifa.wb_data  = wd;  ifb.wb_data  = wd[15:0];
        ifa.ex_flush = fl;  ifb.ex_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b1, mk(OP_LW, 3'd1, 3'd2, 7'd4), 1'b1, 3'd3, 32'h55, 1'b0);
        #1 rst_n = 1'b0;
        #12;
        check("rst_ex_valid", {31'b0, ifa.ex_valid}, 32'd0);
        check("rst_ctrl", {23'b0, ctrl_a()}, 32'd0);
        check("rst_id_ready", {31'b0, ifa.id_ready}, 32'd1);
        check("rst_imm", ifa.ex_imm, 32'd0);
        rst_n = 1'b1;

        for (int i = 1; i < 8; i++) begin
            drive(1'b1, mk(OP_RTYPE, 3'(i), 3'(i), 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
            tick();
            check("post_rst_rd1_a", ifa.ex_rd_data1, 32'd0);
            check("post_rst_rd2_b", {16'b0, ifb.ex_rd_data2}, 32'd0);
        end

        drive(1'b1, mk(OP_RTYPE, 3'd3, 3'd0, 7'd0), 1'b1, 3'd3, 32'h1234, 1'b0);
        tick();
        check("bypass_on", ifa.ex_rd_data1, 32'h1234);
        check("bypass_off", {16'b0, ifb.ex_rd_data1}, 32'h0000);
        check("rtype_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_R});
        check("rtype_rs", {29'b0, ifa.ex_rs}, 32'd3);
        drive(1'b1, mk(OP_RTYPE, 3'd3, 3'd0, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("wb_landed_b", {16'b0, ifb.ex_rd_data1}, 32'h1234);

        drive(1'b1, mk(OP_RTYPE, 3'd0, 3'd0, 7'd0), 1'b1, 3'd0, 32'hFFFF, 1'b0);
        tick();
        check("r0_no_bypass", ifa.ex_rd_data1, 32'd0);
        drive(1'b1, mk(OP_RTYPE, 3'd0, 3'd0, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("r0_no_write", ifa.ex_rd_data1, 32'd0);

        drive(1'b1, mk(OP_LW, 3'd1, 3'd2, 7'd4), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("lw_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_LW});
        check("lw_rt", {29'b0, ifa.ex_rt}, 32'd2);
        check("lw_imm", ifa.ex_imm, 32'd4);
        drive(1'b1, mk(OP_RTYPE, 3'd2, 3'd4, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        #1;
        check("hazard_stall", {31'b0, ifa.id_ready}, 32'd0);
        tick();
        check("hazard_bubble_valid", {31'b0, ifa.ex_valid}, 32'd0);
        check("hazard_bubble_ctrl", {23'b0, ctrl_a()}, 32'd0);
        check("hazard_release", {31'b0, ifa.id_ready}, 32'd1);
        tick();
        check("add_late_valid", {31'b0, ifa.ex_valid}, 32'd1);
        check("add_late_rs", {29'b0, ifa.ex_rs}, 32'd2);
        check("add_late_rt", {29'b0, ifa.ex_rt}, 32'd4);
        check("add_late_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_R});

        drive(1'b1, mk(OP_LW, 3'd1, 3'd0, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        drive(1'b1, mk(OP_RTYPE, 3'd0, 3'd0, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        #1;
        check("lw_r0_no_stall", {31'b0, ifa.id_ready}, 32'd1);
        tick();
        check("lw_r0_next_valid", {31'b0, ifa.ex_valid}, 32'd1);

        drive(1'b1, mk(OP_LW, 3'd1, 3'd5, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        drive(1'b1, mk(OP_RTYPE, 3'd5, 3'd1, 7'd0), 1'b0, 3'd0, 32'd0, 1'b1);
        #1;
        check("flush_over_hazard", {31'b0, ifa.id_ready}, 32'd1);
        tick();
        check("flush_bubble_valid", {31'b0, ifa.ex_valid}, 32'd0);
        check("flush_bubble_ctrl", {23'b0, ctrl_a()}, 32'd0);

        drive(1'b1, mk(OP_ADDI, 3'd1, 3'd1, 7'h7F), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("addi_imm_a", ifa.ex_imm, 32'hFFFF_FFFF);
        check("addi_imm_b", {16'b0, ifb.ex_imm}, 32'h0000_FFFF);
        check("addi_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_ADDI});
        drive(1'b1, mk(OP_ADDI, 3'd1, 3'd1, 7'h3F), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("addi_pos_imm", ifa.ex_imm, 32'h0000_003F);

        drive(1'b1, mk(3'b111, 3'd1, 3'd2, 7'h55), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("op7_valid", {31'b0, ifa.ex_valid}, 32'd1);
        check("op7_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_NONE});
        check("op7_imm", ifa.ex_imm, 32'hFFFF_FFD5);
        drive(1'b1, mk(OP_SW, 3'd1, 3'd2, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("sw_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_SW});
        drive(1'b1, mk(OP_BEQ, 3'd1, 3'd2, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("beq_ctrl", {23'b0, ctrl_a()}, {23'b0, C_CTRL_BEQ});

        drive(1'b0, mk(OP_LW, 3'd1, 3'd2, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        #1;
        check("idle_ready", {31'b0, ifa.id_ready}, 32'd1);
        tick();
        check("idle_bubble_valid", {31'b0, ifa.ex_valid}, 32'd0);
        check("idle_bubble_ctrl", {23'b0, ctrl_a()}, 32'd0);

        drive(1'b1, mk(OP_RTYPE, 3'd1, 3'd2, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("pre_async_valid", {31'b0, ifa.ex_valid}, 32'd1);
        drive(1'b1, mk(OP_RTYPE, 3'd6, 3'd6, 7'd0), 1'b1, 3'd6, 32'hABCD, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, ifa.ex_valid}, 32'd0);
        check("async_rst_ctrl", {23'b0, ctrl_a()}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, mk(OP_RTYPE, 3'd6, 3'd6, 7'd0), 1'b0, 3'd0, 32'd0, 1'b0);
        tick();
        check("lost_write_a", ifa.ex_rd_data1, 32'd0);
        check("lost_write_b", {16'b0, ifb.ex_rd_data2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Pipelined, parametrised decode stage for the 16-bit MIPS-style core. It holds the register file, sign-extends the immediate, decodes control, and registers everything into an ID/EX pipeline register. It adds three features: write-back bypass, load-use hazard stalling, and branch flush. It sits between the IF/ID register and the execute stage.

## Interface
- DATA_W, 16, datapath and register width (≥16); the immediate is sign-extended to DATA_W.
- WB_BYPASS, 1, when 1 a same-cycle write-back to a register being read is forwarded to the read port.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- if_valid  in  1  if_instr holds a real instruction.
- if_instr  in  16  instruction fields: opcode [15:13], rs [12:10], rt [9:7], imm [6:0].
- id_ready  out  1  decode accepts if_instr this cycle; 0 means stall (hold IF/ID).
- wb_we / wb_addr / wb_data  in  1 / 3 / DATA_W  register-file write port.
- ex_flush  in  1  branch taken in EX; squash the instruction in decode.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_rd_data1, ex_rd_data2, ex_imm  out  DATA_W each  operands and sign-extended immediate.
- ex_rs, ex_rt  out  3 each  source register numbers, for the forwarding unit.
- ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each  control signals.
- ex_alu_op  out  2  ALU operation class.

## Operation
- Register file: 8 × DATA_W. r0 always reads 0; writes to r0 are ignored. Writes land on the rising edge when wb_we=1.
- Bypass (WB_BYPASS=1): if wb_we=1, wb_addr≠0 and wb_addr equals rs or rt, that read returns wb_data in the same cycle.
- Control decode by opcode:
  - 000 R-type: reg_dst, reg_write; alu_op=10.
  - 001 lw: alu_src, mem_to_reg, reg_write, mem_read; alu_op=00.
  - 010 sw: alu_src, mem_write; alu_op=00.
  - 011 beq: branch; alu_op=01.
  - 100 addi: alu_src, reg_write; alu_op=00.
  - 101–111: all control signals 0 (NOP).
- Load-use hazard: hazard = ex_valid & ex_mem_read & ex_rt≠0 & (ex_rt==rs | ex_rt==rt).
  - The check is conservative: it compares both fields for every opcode.
  - While hazard=1: id_ready=0, and a bubble is loaded into ID/EX.
- Bubble: ex_valid=0 and all ex_* control signals 0. Data fields are don't-care; the implementation loads 0.
- Flush: ex_flush=1 loads a bubble and forces id_ready=1, so the wrong-path instruction is consumed. Flush overrides hazard.
- if_valid=0 with no flush and no hazard: a bubble is loaded and id_ready=1.
- Otherwise the decoded instruction is loaded with ex_valid=1.

## Timing
- Latency: 1 cycle. Fields accepted at edge N (if_valid & id_ready) appear on ex_* after edge N.
- id_ready is combinational from if_instr, ID/EX state and ex_flush. A load-use stall lasts exactly 1 cycle, because the next ID/EX entry is a bubble.
- Reset (rst_n=0, asynchronous): all ex_* outputs 0 and all registers 0. id_ready is combinational and reads 1, since ex_valid=0.
- Reset asserted mid-stall or mid-write: the state clears immediately and the write is lost.
- Simultaneous write-back and read of the same register with WB_BYPASS=0: the read returns the old value.

## Structure
- decode_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - ALU_OP_* encodings;
  - field position constants;
  - a packed control struct shared with the execute stage.
- One sub-module, regfile_bypass: the 8-entry file with two read ports, one write port, r0 forced to zero and optional bypass.
- Control decode and hazard logic stay in the top-level module.

## Test plan
- Reset: with rst_n low, ex_valid=0, all control outputs 0 and id_ready=1. After release, reading r1–r7 returns 0.
- Bypass: write r3=0x1234 while decoding R-type rs=3. Then ex_rd_data1=0x1234 with WB_BYPASS=1, and 0x0000 with WB_BYPASS=0.
- Load-use: lw with rt=2, then add with rs=2. Expect one cycle of id_ready=0 and a bubble on ex_valid. The add reaches EX one cycle late. A lw to r0 must not stall.
- Flush vs hazard: the hazard condition and ex_flush occur together. Expect id_ready=1 and ex_valid=0 on the next cycle.
- Decode/immediate: addi imm=7'h7F with DATA_W=32 gives ex_imm=32'hFFFFFFFF, alu_src=1, reg_write=1. Opcode 111 gives all control signals 0 with ex_valid=1.
